uart_rx: RTL

UART receiver: the receive-side counterpart to the team's uart_tx, sharing its frame format and bit timing. It deserialises the asynchronous serial line sin into bytes on fpga_clk and presents each byte with a valid/ack handshake. It flags framing and overrun errors. Sits between the board RX pin and the user logic that consumes bytes.

---
 rtl/uart_rx_if.sv | 31 +++
 rtl/uart_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte-side bundle of uart_rx: received byte, valid/ack handshake and error pulses.
// master = receiver, slave = consumer; rx_ack is the only consumer-driven signal.
interface uart_rx_if;
    logic [7:0] dout;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy_rx;
    logic       frame_err;
    logic       overrun_err;
    logic       parity_err;

    modport master (
        output dout,
        output rx_valid,
        output busy_rx,
        output frame_err,
        output overrun_err,
        output parity_err,
        input  rx_ack
    );

    modport slave (
        input  dout,
        input  rx_valid,
        input  busy_rx,
        input  frame_err,
        input  overrun_err,
        input  parity_err,
        output rx_ack
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8 data bits MSB first; rx_valid rises 1 cycle after the stop-bit sample; no backpressure, an unacked byte is overwritten with overrun_err.
// Optional even-parity bit enabled by UART_RX_PARITY_EN (default build: 10-bit frame, parity_err tied 0).
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       fpga_clk,
    input  logic       nrst,
    input  logic       sin,
    uart_rx_if.master  rx
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] HALF_TGT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_TGT = TW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;
    logic [TW-1:0]          tick_cnt;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic [7:0]             dout_q;
    logic                   valid_q;
    logic                   frame_q;
    logic                   overrun_q;

    logic sample, tick_clr, shift_en, accept, frame_bad, start_clr;
`ifdef UART_RX_PARITY_EN
    logic par_smp;
    logic par_bad;
    logic parity_q;
`endif

    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], sin};
    end

    assign rs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick_clr  = 1'b0;
        shift_en  = 1'b0;
        accept    = 1'b0;
        frame_bad = 1'b0;
        start_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        sample    = (state == START) ? (tick_cnt == HALF_TGT) : (tick_cnt == FULL_TGT);
        case (state)
            IDLE: begin
                tick_clr = 1'b1;
                if (!rs) begin
                    state_nxt = START;
                    start_clr = 1'b1;
                end
            end
            START: if (sample) begin
                tick_clr  = 1'b1;
                state_nxt = rs ? IDLE : DATA;
            end
            DATA: if (sample) begin
                tick_clr = 1'b1;
                shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                if (bit_cnt == 3'd7) state_nxt = PARITY;
`else
                if (bit_cnt == 3'd7) state_nxt = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (sample) begin
                tick_clr  = 1'b1;
                par_smp   = 1'b1;
                state_nxt = STOP;
            end
`endif
            STOP: if (sample) begin
                tick_clr = 1'b1;
                if (rs) begin
                    accept    = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    frame_bad = 1'b1;
                    state_nxt = BREAK;
                end
            end
            // A line held low after a bad stop bit must not start a new frame.
            BREAK: begin
                tick_clr = 1'b1;
                if (rs) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            frame_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tick_cnt  <= tick_clr ? '0 : tick_cnt + TW'(1);
            frame_q   <= frame_bad;
            overrun_q <= accept && valid_q && !rx.rx_ack;
            if (state == START)  bit_cnt <= '0;
            else if (shift_en)   bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)        shreg <= {shreg[6:0], rs};
            if (accept) begin
                dout_q  <= shreg;
                valid_q <= 1'b1;
            end else if (rx.rx_ack) begin
                valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge fpga_clk or negedge nrst) begin
        if (!nrst) begin
            par_bad  <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            parity_q <= accept && par_bad;
            if (start_clr || accept) par_bad <= 1'b0;
            else if (par_smp)        par_bad <= ^shreg ^ rs;
        end
    end
    assign rx.parity_err = parity_q;
`else
    assign rx.parity_err = 1'b0;
`endif

    assign rx.dout        = dout_q;
    assign rx.rx_valid    = valid_q;
    assign rx.busy_rx     = (state != IDLE);
    assign rx.frame_err   = frame_q;
    assign rx.overrun_err = overrun_q;

endmodule
